// File: rtl/hyper_cfg_sequencer_if.sv
// Register bus: the initiator drives addr/write/wdata/wstrb/valid and the target answers with rdata/error/ready.
// A transfer completes in the cycle where valid and ready are both high.
// The target stalls the initiator by holding ready low.
interface REG_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    error;
    logic                    valid;
    logic                    ready;

    modport in  (input addr, write, wdata, wstrb, valid, output rdata, error, ready);
    modport out (output addr, write, wdata, wstrb, valid, input rdata, error, ready);
endinterface

// File: rtl/hyper_cfg_sequencer.sv
// Writes an (addr, data, mask) table over the register bus, then optionally reads it back and compares.
// Latency: one transfer per cycle at best, and done_o comes one cycle after the last transfer.
// Backpressure: the request is held while ready is low, and the run aborts after TIMEOUT waiting cycles.
module hyper_cfg_sequencer #(
    parameter  int unsigned NR_ENTRIES = 9,
    parameter  int unsigned TIMEOUT    = 255,
    localparam int unsigned IW         = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    REG_BUS.out                      cfg_o,
    input  logic                     start_i,
    input  logic                     verify_i,
    input  logic [NR_ENTRIES*32-1:0] tbl_addr_i,
    input  logic [NR_ENTRIES*32-1:0] tbl_data_i,
    input  logic [NR_ENTRIES*32-1:0] tbl_mask_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [1:0]               err_code_o,
    output logic [IW-1:0]            fail_idx_o
);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_READ   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_BUS      = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    localparam logic [IW-1:0] LAST_IDX = IW'(NR_ENTRIES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          verify_q, verify_d;
    logic [1:0]    err_q, err_d;
    logic [IW-1:0] fidx_q, fidx_d;

    logic [31:0] cur_addr, cur_data, cur_mask;
    logic        bus_vld, xfer, rd_mismatch;

    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        cur_mask = '0;
        for (int k = 0; k < NR_ENTRIES; k++) begin
            if (idx_q == IW'(k)) begin
                cur_addr = tbl_addr_i[32*k +: 32];
                cur_data = tbl_data_i[32*k +: 32];
                cur_mask = tbl_mask_i[32*k +: 32];
            end
        end
    end

    assign bus_vld     = (state_q == S_WRITE) || (state_q == S_READ);
    assign xfer        = bus_vld && cfg_o.ready;
    assign rd_mismatch = ((cfg_o.rdata ^ cur_data) & cur_mask) != 32'd0;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        verify_d = verify_q;
        err_d    = err_q;
        fidx_d   = fidx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_WRITE;
                    idx_d    = '0;
                    cnt_d    = '0;
                    verify_d = verify_i;
                    err_d    = ERR_OK;
                    fidx_d   = '0;
                end
            end
            S_WRITE, S_READ: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (cfg_o.error) begin
                        err_d   = ERR_BUS;
                        fidx_d  = idx_q;
                        state_d = S_FINISH;
                    end else begin
                        // Only the first mismatch of a run is reported.
                        if (state_q == S_READ && rd_mismatch && err_q != ERR_MISMATCH) begin
                            err_d  = ERR_MISMATCH;
                            fidx_d = idx_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = (state_q == S_WRITE && verify_q) ? S_READ : S_FINISH;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    err_d   = ERR_TIMEOUT;
                    fidx_d  = idx_q;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            verify_q <= 1'b0;
            err_q    <= ERR_OK;
            fidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            verify_q <= verify_d;
            err_q    <= err_d;
            fidx_q   <= fidx_d;
        end
    end

    // Bus outputs decode from the state register, so reset drops valid immediately.
    assign cfg_o.valid = bus_vld;
    assign cfg_o.write = (state_q == S_WRITE);
    assign cfg_o.addr  = bus_vld ? cur_addr : 32'd0;
    assign cfg_o.wdata = (state_q == S_WRITE) ? cur_data : 32'd0;
    assign cfg_o.wstrb = (state_q == S_WRITE) ? 4'hF : 4'h0;

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_FINISH);
    assign err_code_o = err_q;
    assign fail_idx_o = fidx_q;
endmodule

// File: tb/tb_hyper_cfg_sequencer.sv
// Bench for hyper_cfg_sequencer: a random-wait responder, a scoreboard of expected transfers and results,
// and a table-level reference model.
module tb_hyper_cfg_sequencer;
    localparam int N  = 9;
    localparam int TO = 8;
    localparam int IW = 4;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic [1:0]    code;
        logic [IW-1:0] fidx;
    } res_t;

    logic            clk_i = 1'b0;
    logic            rst_ni, start_i, verify_i;
    logic [N*32-1:0] tbl_addr_i, tbl_data_i, tbl_mask_i;
    logic            busy_o, done_o;
    logic [1:0]      err_code_o;
    logic [IW-1:0]   fail_idx_o;

    REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    hyper_cfg_sequencer #(.NR_ENTRIES(N), .TIMEOUT(TO)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cfg_o      (bus),
        .start_i    (start_i),
        .verify_i   (verify_i),
        .tbl_addr_i (tbl_addr_i),
        .tbl_data_i (tbl_data_i),
        .tbl_mask_i (tbl_mask_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_code_o (err_code_o),
        .fail_idx_o (fail_idx_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit abort = 0;

    xfer_t xq[$];
    res_t  rq[$];

    logic [31:0] t_addr [N];
    logic [31:0] t_data [N];
    logic [31:0] t_mask [N];

    // Fault kinds: 0 none, 1 bus error, 2 ready held low. Phase: 0 write, 1 read.
    int         flt_kind = 0;
    int         flt_ph   = 0;
    int         flt_idx  = 0;
    bit [N-1:0] corrupt  = '0;
    bit         zero_wait = 1;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at time %0t", nm, $time);
    endtask

    // Target side of the register bus.
    int r_e, r_ph, wait_run;
    bit r_stall;
    initial begin
        bus.ready = 1'b0;
        bus.error = 1'b0;
        bus.rdata = '0;
        wait_run  = 0;
        forever begin
            @(posedge clk_i);
            #1;
            bus.ready = 1'b0;
            bus.error = 1'b0;
            bus.rdata = '0;
            if (bus.valid) begin
                r_e = int'(bus.addr[7:0]);
                if (r_e >= N) r_e = 0;
                r_ph    = bus.write ? 0 : 1;
                r_stall = (flt_kind == 2) && (flt_ph == r_ph) && (flt_idx == r_e);
                if (r_stall) begin
                    bus.ready = 1'b0;
                end else if (zero_wait || wait_run >= 3 || $urandom_range(0, 2) != 0) begin
                    bus.ready = 1'b1;
                    wait_run  = 0;
                end else begin
                    wait_run++;
                end
                if (bus.ready) begin
                    bus.error = (flt_kind == 1) && (flt_ph == r_ph) && (flt_idx == r_e);
                    if (r_ph == 1) begin
                        bus.rdata = (t_data[r_e] & t_mask[r_e]) | ($urandom() & ~t_mask[r_e]);
                        if (corrupt[r_e]) bus.rdata = bus.rdata ^ (t_mask[r_e] & (~t_mask[r_e] + 32'd1));
                    end
                end
            end
        end
    end

    // Monitor: checks every cycle and every completed transfer against the scoreboard.
    xfer_t got, held, exp_x;
    res_t  exp_r;
    bit    hold_pend = 0;
    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            hold_pend = 0;
        end else begin
            got = '{wr: bus.write, addr: bus.addr, wdata: bus.wdata};
            if (!bus.valid) chk("idle_bus", {got, bus.wstrb}, '0);
            if (hold_pend && bus.valid) chk("hold_stable", got, held);
            if (bus.valid && bus.ready) begin
                if (xq.size() == 0) begin
                    fail_now("xfer_unexpected");
                end else begin
                    exp_x = xq.pop_front();
                    chk("xfer", got, exp_x);
                    chk("wstrb", bus.wstrb, exp_x.wr ? 4'hF : 4'h0);
                end
            end
            hold_pend = bus.valid && !bus.ready;
            held      = got;
            if (done_o) begin
                if (rq.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    exp_r = rq.pop_front();
                    chk("result", {err_code_o, fail_idx_o}, exp_r);
                    chk("xfers_left", xq.size(), 0);
                end
            end
        end
    end

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            tbl_addr_i[32*k +: 32] = t_addr[k];
            tbl_data_i[32*k +: 32] = t_data[k];
            tbl_mask_i[32*k +: 32] = t_mask[k];
        end
    endtask

    task automatic setup(input bit force_mask);
        for (int k = 0; k < N; k++) begin
            t_addr[k] = ($urandom() & 32'hFFFF_FF00) | 32'(k);
            t_data[k] = $urandom();
            case ($urandom_range(0, 3))
                0:       t_mask[k] = 32'hFFFF_FFFF;
                1:       t_mask[k] = 32'h0;
                2:       t_mask[k] = 32'h0000_000F;
                default: t_mask[k] = $urandom();
            endcase
            if (force_mask && t_mask[k] == 32'h0) t_mask[k] = 32'h1;
        end
        pack();
    endtask

    // Table-level reference: walk the write list then the read list and stop at the first bus fault.
    task automatic model(input bit vfy, input int fk, input int fph, input int fi, input bit [N-1:0] cor,
                         output int ncomp, output res_t r, output bit to);
        bit stop = 0;
        ncomp = 0;
        r     = '0;
        to    = 0;
        for (int ph = 0; ph < (vfy ? 2 : 1); ph++) begin
            for (int k = 0; k < N; k++) begin
                if (!stop) begin
                    if (fk == 2 && fph == ph && fi == k) begin
                        r    = '{code: 2'b10, fidx: IW'(k)};
                        to   = 1;
                        stop = 1;
                    end else begin
                        xq.push_back('{wr: (ph == 0), addr: t_addr[k], wdata: (ph == 0) ? t_data[k] : 32'd0});
                        ncomp++;
                        if (fk == 1 && fph == ph && fi == k) begin
                            r    = '{code: 2'b01, fidx: IW'(k)};
                            stop = 1;
                        end else if (ph == 1 && cor[k] && t_mask[k] != 32'h0 && r.code == 2'b00) begin
                            r = '{code: 2'b11, fidx: IW'(k)};
                        end
                    end
                end
            end
        end
    endtask

    task automatic kick(input bit vfy);
        @(posedge clk_i);
        #1;
        verify_i = vfy;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        verify_i = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input bit vfy, input int fk, input int fph, input int fi, input bit [N-1:0] cor, input bit zw);
        int   ncomp, lat;
        res_t r;
        bit   to, got_done;
        if (abort) return;
        flt_kind  = fk;
        flt_ph    = fph;
        flt_idx   = fi;
        corrupt   = cor;
        zero_wait = zw;
        model(vfy, fk, fph, fi, cor, ncomp, r, to);
        rq.push_back(r);
        kick(vfy);
        lat      = 0;
        got_done = 0;
        for (int c = 0; c < 1000 && !got_done; c++) begin
            @(negedge clk_i);
            lat++;
            // A start request mid-run must be ignored.
            if (lat == 1) start_i = 1'b1;
            if (lat == 2) start_i = 1'b0;
            if (done_o) got_done = 1;
        end
        start_i = 1'b0;
        if (!got_done) begin
            fail_now("done_timeout");
            abort = 1;
            return;
        end
        if (zw) chk("done_latency", lat, ncomp + (to ? TO : 0) + 1);
        repeat (3) @(negedge clk_i);
        chk("err_held", {busy_o, err_code_o, fail_idx_o}, {1'b0, r});
    endtask

    int   rs_n;
    res_t rs_r;
    bit   rs_to;
    initial begin
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        verify_i   = 1'b0;
        tbl_addr_i = '0;
        tbl_data_i = '0;
        tbl_mask_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_outputs", {bus.valid, busy_o, done_o, err_code_o, fail_idx_o}, '0);
        rst_ni = 1'b1;

        setup(1); run(0, 0, 0, 0, '0, 1);
        setup(1); t_data[0] = 32'h16; t_mask[0] = 32'hF; pack(); run(1, 0, 0, 0, '0, 1);
        setup(1); run(1, 0, 0, 0, 9'b0_0101_0000, 1);
        setup(1); run(0, 1, 0, 2, '0, 1);
        setup(1); run(1, 2, 0, 3, '0, 1);

        // Reset while the bus is stalled at entry 3: valid drops at once and no done follows.
        if (!abort) begin
            setup(1);
            flt_kind = 2; flt_ph = 0; flt_idx = 3; corrupt = '0; zero_wait = 1;
            model(0, 2, 0, 3, '0, rs_n, rs_r, rs_to);
            kick(0);
            repeat (7) @(negedge clk_i);
            chk("pre_rst_valid", bus.valid, 1);
            rst_ni = 1'b0;
            #1;
            chk("rst_mid_xfer", {bus.valid, busy_o, done_o, err_code_o, fail_idx_o}, '0);
            repeat (2) @(negedge clk_i);
            chk("rst_no_done", done_o, 0);
            rst_ni   = 1'b1;
            flt_kind = 0;
            chk("xq_after_rst", xq.size(), 0);
        end

        setup(1); run(0, 0, 0, 0, '0, 0);
        setup(1); run(1, 2, 1, 7, 9'b0_0010_0100, 1);
        setup(1); run(1, 1, 1, 5, 9'b0_0000_0010, 0);
        setup(1); run(1, 0, 0, 0, 9'b1_0000_0001, 1);

        for (int i = 0; i < 24; i++) begin
            setup(1'($urandom_range(0, 1)));
            run(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 2)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), N'($urandom()),
                1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
